rtc_timekeeper: RTL and testbench
=================================

Name: rtc_timekeeper

Overview:
- Owns the 60-bit BCD real-time-clock register that the S-RTC emulation reads.
- Shares that register between three requesters: the MCU (time set), the S-RTC core (game-side writes) and an internal 1 Hz tick.
- The tick advances the time through a multi-cycle carry-ripple FSM.
- Sits between the MCU interface, the srtc core and the RTC snapshot path.

Parameters:
- CLK_HZ, 96000000, clkin frequency; prescaler terminal count is CLK_HZ-1. Must be >= 16.
- RESET_TIME, 60'h0_1999_0101_000000 (weekday 0, 4-digit year 1999, month 01, day 01, 00:00:00), value loaded on reset.

Ports:
- clkin  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  1 = prescaler counts; 0 = time frozen, prescaler held.
- mcu_we  in  1  level strobe; rising edge requests a write of mcu_data.
- mcu_data  in  60  time value captured on the mcu_we rising edge.
- srtc_we  in  1  level strobe from the srtc core; rising edge requests a write of srtc_data.
- srtc_data  in  60  time value captured on the srtc_we rising edge.
- rtc_data  out  60  current time, registered.
- busy  out  1  high while the FSM is not IDLE.
- sec_pulse  out  1  one-cycle pulse when the prescaler wraps.
- update_done  out  1  one-cycle pulse after any write or increment completes.

Behaviour:
Register layout (4-bit BCD nibbles):
- [3:0]/[7:4] sec, [11:8]/[15:12] min, [19:16]/[23:20] hour, [27:24]/[31:28] day, [35:32]/[39:36] month.
- [55:40] year as 4 digits, low digit first.
- [59:56] weekday, 0-6.

Reset:
- rtc_data = RESET_TIME; prescaler = 0; all pending flags cleared.
- FSM = IDLE; busy, sec_pulse and update_done all = 0.
- A reset in the middle of an increment or write abandons it. No update_done pulse is issued.

Request capture:
- mcu_we and srtc_we each pass through a 2-flop synchroniser plus edge detector.
- A rising edge latches the matching data bus into a pending buffer and sets that requester's pending flag. Capture happens in every FSM state.
- A new edge while the flag is still set overwrites the buffer (last write wins).

Prescaler:
- Counts while tick_en = 1. At CLK_HZ-1 it wraps to 0, pulses sec_pulse and sets tick_pending.
- tick_pending is a single saturating flag; a second tick while it is set is lost.
- An applied MCU write clears both the prescaler and tick_pending.

FSM states:
- IDLE: arbitration priority is MCU, then SRTC, then TICK.
  - mcu_pending → WRITE_MCU. If srtc_pending is set in the same cycle it is cleared (dropped).
  - else srtc_pending → WRITE_SRTC.
  - else tick_pending → INC_SEC, clearing tick_pending.
- WRITE_MCU / WRITE_SRTC: load rtc_data from the buffer, clear the flag → DONE. One cycle.
- INC_SEC, INC_MIN, INC_HOUR: field = field+1 (BCD).
  - If field >= max (59, 59, 23) before the increment, write 00 and go to the next state.
  - Otherwise go to DONE.
- INC_DAY:
  - Weekday increments mod 7 every time this state is entered; a weekday >= 6 wraps to 0.
  - If day >= days_in_month(month, year), write 01 → INC_MON; else day+1 → DONE.
- INC_MON: if month >= 12, write 01 → INC_YEAR; else month+1 → DONE.
- INC_YEAR: 4-digit BCD +1 in one cycle; 9999 wraps to 0000 → DONE.
- DONE: pulse update_done → IDLE.

Latency and arithmetic:
- Write: 3 cycles from the IDLE cycle to the update_done pulse.
- Increment: 3 to 8 cycles.
- Fields are compared as binary on the BCD value, so any corrupt nibble >= max is forced to wrap. Digit values A-F in a low nibble carry as 9.
- Requests arriving while busy stay pending and are served on the next IDLE cycle. A write that arrives during an increment therefore overwrites the increment result.

Optional Feature:
- RTC_LEAP_YEAR_EN defined: February has 29 days when the year is divisible by 4, except years divisible by 100 and not by 400.
- RTC_LEAP_YEAR_EN undefined: February always has 28 days.

Decomposition:
- Package rtc_pkg holds:
  - field bit offsets;
  - FSM state encoding, one-hot with 10 states;
  - BCD max constants (8'h59, 8'h23, 8'h12);
  - the days-per-month table.
- Sub-module rtc_days_in_month: purely combinational. Inputs are month BCD (8) and year BCD (16); output is the last-day BCD (8). The leap-year logic is isolated here.

Test Plan:
- Reset with CLK_HZ=16 → rtc_data = RESET_TIME. 16 cycles later sec_pulse fires; update_done follows within 4 cycles and sec = 01.
- MCU writes 0_1999_1231_235959 (weekday 0), then one tick → 1_2000_0101_000000. The path walks all INC states; update_done arrives 8 cycles after IDLE.
- Weekday-0 value 0_2000_0228_235959, tick:
  - with RTC_LEAP_YEAR_EN: day 29, month 02, weekday 1;
  - without it: 0301.
- Same case with year 2100 → 0301 regardless of the macro.
- mcu_we and srtc_we rise in the same cycle with different data → rtc_data = mcu_data; the srtc value is never applied; only one update_done.
- srtc_we rises while the FSM is in INC_MIN → increment completes (update_done), then the SRTC write is applied (second update_done); final rtc_data = srtc_data.
- Reset asserted during INC_HOUR → next cycle rtc_data = RESET_TIME, busy = 0, no update_done.
- Seconds field forced to 0x7A, tick → sec = 00, carry into minutes.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the RTC timekeeper.
package rtc_pkg;

  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = 8;
  localparam int HOUR_LSB = 16;
  localparam int DAY_LSB  = 24;
  localparam int MON_LSB  = 32;
  localparam int YEAR_LSB = 40;
  localparam int WDAY_LSB = 56;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MON_MAX  = 8'h12;

  typedef enum logic [9:0] {
    ST_IDLE       = 10'b00_0000_0001,
    ST_WRITE_MCU  = 10'b00_0000_0010,
    ST_WRITE_SRTC = 10'b00_0000_0100,
    ST_INC_SEC    = 10'b00_0000_1000,
    ST_INC_MIN    = 10'b00_0001_0000,
    ST_INC_HOUR   = 10'b00_0010_0000,
    ST_INC_DAY    = 10'b00_0100_0000,
    ST_INC_MON    = 10'b00_1000_0000,
    ST_INC_YEAR   = 10'b01_0000_0000,
    ST_DONE       = 10'b10_0000_0000
  } rtc_state_e;

  // Indexed by binary month 1-12; unused slots read as 31 so a corrupt month still wraps.
  localparam logic [7:0] DAYS_TABLE [16] = '{
    8'h31, 8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31,
    8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h31, 8'h31, 8'h31
  };

  // Low digit A-F is treated as 9 and carries.
  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Last day of a month in BCD. Leap-year February only when RTC_LEAP_YEAR_EN is defined.
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [7:0]  month,
  input  logic [15:0] year,
  output logic [7:0]  last_day
);

  logic [3:0] idx;
  logic       leap;

  always_comb begin
    idx = 4'd0;
    if (month[7:5] != 3'd0) idx = 4'd0;
    else if (month[4])      idx = month[3:0] + 4'd10;
    else                    idx = month[3:0];
  end

`ifdef RTC_LEAP_YEAR_EN
  // Two BCD digits divisible by 4: even tens need 0/4/8, odd tens need 2/6.
  function automatic logic div4(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  assign leap = div4(year[7:0]) && ((year[7:0] != 8'h00) || div4(year[15:8]));
`else
  logic unused_year;
  assign unused_year = ^year;
  assign leap        = 1'b0;
`endif

  assign last_day = (month == 8'h02 && leap) ? 8'h29 : DAYS_TABLE[idx];

endmodule

// File: rtl/rtc_timekeeper.sv
// 60-bit BCD RTC register shared by MCU writes, S-RTC writes and a 1 Hz carry-ripple tick.
// Optional leap-year February handling is enabled with RTC_LEAP_YEAR_EN.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int          CLK_HZ     = 96000000,
  parameter logic [59:0] RESET_TIME = 60'h0_1999_0101_000000
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        tick_en,
  input  logic        mcu_we,
  input  logic [59:0] mcu_data,
  input  logic        srtc_we,
  input  logic [59:0] srtc_data,
  output logic [59:0] rtc_data,
  output logic        busy,
  output logic        sec_pulse,
  output logic        update_done
);

  localparam int            PW   = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

  rtc_state_e    state, state_nxt;
  logic [59:0]   rtc_nxt;
  logic [59:0]   mcu_buf, srtc_buf;
  logic          mcu_pend, srtc_pend, tick_pend;
  logic [2:0]    mcu_sync, srtc_sync;
  logic          mcu_rise, srtc_rise;
  logic [PW-1:0] presc;
  logic          wrap;
  logic          mcu_clr, srtc_clr, tick_clr, presc_clr;
  logic [7:0]    last_day;

  // Requests are level strobes: only the synchronised rising edge captures data,
  // and the pending flag holds it until the FSM consumes it from IDLE.
  assign mcu_rise  = mcu_sync[1] & ~mcu_sync[2];
  assign srtc_rise = srtc_sync[1] & ~srtc_sync[2];
  assign wrap      = tick_en && (presc == TERM) && !presc_clr;
  assign busy      = (state != ST_IDLE);

  rtc_days_in_month u_dim (
    .month    (rtc_data[MON_LSB +: 8]),
    .year     (rtc_data[YEAR_LSB +: 16]),
    .last_day (last_day)
  );

  always_comb begin
    state_nxt = state;
    rtc_nxt   = rtc_data;
    mcu_clr   = 1'b0;
    srtc_clr  = 1'b0;
    tick_clr  = 1'b0;
    presc_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mcu_pend) begin
          state_nxt = ST_WRITE_MCU;
          srtc_clr  = 1'b1;
        end else if (srtc_pend) begin
          state_nxt = ST_WRITE_SRTC;
        end else if (tick_pend) begin
          state_nxt = ST_INC_SEC;
          tick_clr  = 1'b1;
        end
      end
      ST_WRITE_MCU: begin
        rtc_nxt   = mcu_buf;
        mcu_clr   = 1'b1;
        presc_clr = 1'b1;
        tick_clr  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_WRITE_SRTC: begin
        rtc_nxt   = srtc_buf;
        srtc_clr  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_INC_SEC: begin
        if (rtc_data[SEC_LSB +: 8] >= SEC_MAX) begin
          rtc_nxt[SEC_LSB +: 8] = 8'h00;
          state_nxt = ST_INC_MIN;
        end else begin
          rtc_nxt[SEC_LSB +: 8] = bcd_inc2(rtc_data[SEC_LSB +: 8]);
          state_nxt = ST_DONE;
        end
      end
      ST_INC_MIN: begin
        if (rtc_data[MIN_LSB +: 8] >= MIN_MAX) begin
          rtc_nxt[MIN_LSB +: 8] = 8'h00;
          state_nxt = ST_INC_HOUR;
        end else begin
          rtc_nxt[MIN_LSB +: 8] = bcd_inc2(rtc_data[MIN_LSB +: 8]);
          state_nxt = ST_DONE;
        end
      end
      ST_INC_HOUR: begin
        if (rtc_data[HOUR_LSB +: 8] >= HOUR_MAX) begin
          rtc_nxt[HOUR_LSB +: 8] = 8'h00;
          state_nxt = ST_INC_DAY;
        end else begin
          rtc_nxt[HOUR_LSB +: 8] = bcd_inc2(rtc_data[HOUR_LSB +: 8]);
          state_nxt = ST_DONE;
        end
      end
      ST_INC_DAY: begin
        rtc_nxt[WDAY_LSB +: 4] = (rtc_data[WDAY_LSB +: 4] >= 4'd6) ? 4'd0
                                                                   : rtc_data[WDAY_LSB +: 4] + 4'd1;
        if (rtc_data[DAY_LSB +: 8] >= last_day) begin
          rtc_nxt[DAY_LSB +: 8] = 8'h01;
          state_nxt = ST_INC_MON;
        end else begin
          rtc_nxt[DAY_LSB +: 8] = bcd_inc2(rtc_data[DAY_LSB +: 8]);
          state_nxt = ST_DONE;
        end
      end
      ST_INC_MON: begin
        if (rtc_data[MON_LSB +: 8] >= MON_MAX) begin
          rtc_nxt[MON_LSB +: 8] = 8'h01;
          state_nxt = ST_INC_YEAR;
        end else begin
          rtc_nxt[MON_LSB +: 8] = bcd_inc2(rtc_data[MON_LSB +: 8]);
          state_nxt = ST_DONE;
        end
      end
      ST_INC_YEAR: begin
        rtc_nxt[YEAR_LSB +: 16] = bcd_inc4(rtc_data[YEAR_LSB +: 16]);
        state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= ST_IDLE;
      rtc_data    <= RESET_TIME;
      mcu_buf     <= '0;
      srtc_buf    <= '0;
      mcu_pend    <= 1'b0;
      srtc_pend   <= 1'b0;
      tick_pend   <= 1'b0;
      mcu_sync    <= '0;
      srtc_sync   <= '0;
      presc       <= '0;
      sec_pulse   <= 1'b0;
      update_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      rtc_data    <= rtc_nxt;
      mcu_sync    <= {mcu_sync[1:0], mcu_we};
      srtc_sync   <= {srtc_sync[1:0], srtc_we};
      sec_pulse   <= wrap;
      update_done <= (state == ST_DONE);

      // A fresh edge wins over a same-cycle clear so the newest request is never lost.
      if (mcu_rise) begin
        mcu_buf  <= mcu_data;
        mcu_pend <= 1'b1;
      end else if (mcu_clr) begin
        mcu_pend <= 1'b0;
      end

      if (srtc_rise) begin
        srtc_buf  <= srtc_data;
        srtc_pend <= 1'b1;
      end else if (srtc_clr) begin
        srtc_pend <= 1'b0;
      end

      if (presc_clr)    presc <= '0;
      else if (tick_en) presc <= (presc == TERM) ? '0 : presc + PW'(1);

      if (wrap)          tick_pend <= 1'b1;
      else if (tick_clr) tick_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with a 16-cycle second; expectations are hand-computed.
module tb_rtc_timekeeper;

  localparam logic [59:0] RESET_TIME = 60'h0_1999_0101_000000;

  logic        clkin;
  logic        reset;
  logic        tick_en;
  logic        mcu_we;
  logic [59:0] mcu_data;
  logic        srtc_we;
  logic [59:0] srtc_data;
  logic [59:0] rtc_data;
  logic        busy;
  logic        sec_pulse;
  logic        update_done;

  int vectors     = 0;
  int miscompares = 0;

  rtc_timekeeper #(.CLK_HZ(16), .RESET_TIME(RESET_TIME)) dut (
    .clkin       (clkin),
    .reset       (reset),
    .tick_en     (tick_en),
    .mcu_we      (mcu_we),
    .mcu_data    (mcu_data),
    .srtc_we     (srtc_we),
    .srtc_data   (srtc_data),
    .rtc_data    (rtc_data),
    .busy        (busy),
    .sec_pulse   (sec_pulse),
    .update_done (update_done)
  );

  // clock/reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // which: 0 = sec_pulse, 1 = update_done; n = cycles until seen, -1 on timeout
  task automatic wait_for(input int which, input int max, output int n);
    int  i;
    bit  seen;
    n    = -1;
    seen = 1'b0;
    i    = 0;
    while (!seen && i < max) begin
      step(1);
      i++;
      if ((which == 0 && sec_pulse) || (which == 1 && update_done)) begin
        seen = 1'b1;
        n    = i;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (update_done) cnt++;
    end
  endtask

  // driver: MCU write, 2 sync + 1 capture + 3 FSM cycles to update_done
  task automatic mcu_write(input string tag, input logic [59:0] v);
    int n;
    mcu_data = v;
    mcu_we   = 1'b1;
    wait_for(1, 20, n);
    check({tag, " wr_lat"}, 64'(n), 64'd6);
    check({tag, " wr_val"}, 64'(rtc_data), 64'(v));
    mcu_we = 1'b0;
    step(3);
  endtask

  // driver: one tick from a cleared prescaler
  task automatic do_tick(input string tag, input int exp_lat, input logic [59:0] exp_val);
    int n;
    tick_en = 1'b1;
    wait_for(0, 40, n);
    tick_en = 1'b0;
    check({tag, " sec_lat"}, 64'(n), 64'd16);
    wait_for(1, 12, n);
    check({tag, " done_lat"}, 64'(n), 64'(exp_lat));
    check({tag, " val"}, 64'(rtc_data), 64'(exp_val));
  endtask

  initial begin
    int n;
    int cnt;
    reset     = 1'b1;
    tick_en   = 1'b0;
    mcu_we    = 1'b0;
    mcu_data  = '0;
    srtc_we   = 1'b0;
    srtc_data = '0;
    step(3);
    check("rst rtc", 64'(rtc_data), 64'(RESET_TIME));
    check("rst busy", 64'(busy), 64'd0);
    check("rst sec_pulse", 64'(sec_pulse), 64'd0);
    check("rst update_done", 64'(update_done), 64'd0);
    reset = 1'b0;

    do_tick("t1 first_sec", 3, 60'h0_1999_0101_000001);

    mcu_write("t2", 60'h0_1999_1231_235959);
    do_tick("t2 new_year", 8, 60'h1_2000_0101_000000);

    mcu_write("t3", 60'h0_2000_0228_235959);
`ifdef RTC_LEAP_YEAR_EN
    do_tick("t3 leap_feb", 6, 60'h1_2000_0229_000000);
`else
    do_tick("t3 feb_end", 7, 60'h1_2000_0301_000000);
`endif

    mcu_write("t4", 60'h0_2100_0228_235959);
    do_tick("t4 century", 7, 60'h1_2100_0301_000000);

    // simultaneous requests: MCU wins, SRTC dropped
    mcu_data  = 60'h2_2010_0505_101010;
    srtc_data = 60'h4_2011_0606_111111;
    mcu_we    = 1'b1;
    srtc_we   = 1'b1;
    wait_for(1, 20, n);
    check("t5 lat", 64'(n), 64'd6);
    check("t5 val", 64'(rtc_data), 64'h0_2_2010_0505_101010);
    count_done(12, cnt);
    check("t5 extra_done", 64'(cnt), 64'd0);
    check("t5 hold", 64'(rtc_data), 64'h0_2_2010_0505_101010);
    mcu_we  = 1'b0;
    srtc_we = 1'b0;
    step(3);

    // SRTC write raised while in INC_MIN is served after the increment
    mcu_write("t6", 60'h0_2000_0101_000059);
    tick_en = 1'b1;
    wait_for(0, 40, n);
    tick_en = 1'b0;
    check("t6 sec_lat", 64'(n), 64'd16);
    step(2);
    srtc_data = 60'h3_2024_0615_123456;
    srtc_we   = 1'b1;
    wait_for(1, 12, n);
    check("t6 inc_lat", 64'(n), 64'd2);
    check("t6 inc_val", 64'(rtc_data), 64'h0_0_2000_0101_000100);
    wait_for(1, 12, n);
    check("t6 srtc_lat", 64'(n), 64'd4);
    check("t6 srtc_val", 64'(rtc_data), 64'h0_3_2024_0615_123456);
    srtc_we = 1'b0;
    step(3);

    // reset during INC_HOUR
    mcu_write("t7", 60'h0_2000_0101_005959);
    tick_en = 1'b1;
    wait_for(0, 40, n);
    tick_en = 1'b0;
    check("t7 sec_lat", 64'(n), 64'd16);
    step(3);
    check("t7 busy_inc", 64'(busy), 64'd1);
    reset = 1'b1;
    step(1);
    check("t7 rst rtc", 64'(rtc_data), 64'(RESET_TIME));
    check("t7 rst busy", 64'(busy), 64'd0);
    check("t7 rst done", 64'(update_done), 64'd0);
    reset = 1'b0;
    count_done(10, cnt);
    check("t7 no_done", 64'(cnt), 64'd0);
    check("t7 hold", 64'(rtc_data), 64'(RESET_TIME));

    // corrupt seconds nibble wraps and carries
    mcu_write("t8", 60'h0_2000_0101_00007A);
    do_tick("t8 corrupt_sec", 4, 60'h0_2000_0101_000100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
